// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM state encoding and
// the bit positions of the {c, v, n, z} flag vector.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_INC  = 4'h8;
    localparam logic [3:0] OP_DEC  = 4'h9;
    localparam logic [3:0] OP_NAND = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;
    localparam logic [3:0] OP_XNOR = 4'hC;
    localparam logic [3:0] OP_CMP  = 4'hD;
    localparam logic [3:0] OP_MUL  = 4'hE;
    localparam logic [3:0] OP_ADC  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_C = 3;

    function automatic logic [3:0] pack_flags(input logic c, input logic v,
                                              input logic n, input logic z);
        logic [3:0] f;
        f         = '0;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operation request / result handshake bundle between a producer (master)
// and the sequential ALU (slave).
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       s;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       flags;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output a, b, s, in_valid, out_ready,
        input  in_ready, alu_result, flags, out_valid
    );

    modport slave (
        input  a, b, s, in_valid, out_ready,
        output in_ready, alu_result, flags, out_valid
    );
endinterface

// File: rtl/alu_shift_add_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles
// after start; product/done are valid combinationally on the final iteration.
module alu_shift_add_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_p0;
    logic [2*WIDTH-1:0] acc_p0;
    logic [WIDTH-1:0]   mplier_p0;
    logic [CNT_W-1:0]   cnt;
    logic               busy;
    logic [2*WIDTH-1:0] step;

    // Accumulator plus the current partial product; on the last iteration
    // this is the full product, so the parent can capture it directly.
    always_comb begin
        step    = acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);
        product = step;
        done    = busy && (cnt == CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= CNT_W'(WIDTH);
        end else if (busy) begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
                busy <= 1'b0;
            end
        end
    end

    // ---- iteration datapath ----
    always_ff @(posedge clk) begin
        if (start) begin
            mcand_p0  <= {{WIDTH{1'b0}}, a};
            mplier_p0 <= b;
            acc_p0    <= '0;
        end else if (busy) begin
            mcand_p0  <= mcand_p0 << 1;
            mplier_p0 <= mplier_p0 >> 1;
            acc_p0    <= step;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake: single-cycle ops land in HOLD one
// cycle after acceptance; MUL runs through the shift-add multiplier first.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [3:0]       flags;
    } alu_out_t;

    state_e             state;
    state_e             state_nxt;
    logic               in_ready_c;
    logic               accept;
    logic               is_mul_op;
    logic               mul_start;
    logic               mul_done;
    logic [3:0]         op_eff;
    logic [2*WIDTH-1:0] mul_prod;
    alu_out_t           single_out;
    alu_out_t           mul_out;

    logic [WIDTH-1:0]   result_p1;
    logic [3:0]         flags_p1;
    logic               vld_p1;
    logic               carry_p1;

    // Evaluates every single-cycle op on a WIDTH+1 bit sum; the signed copy
    // of the sum detects two's-complement overflow from its top two bits.
    function automatic alu_out_t eval_op(input logic [3:0]       op,
                                         input logic [WIDTH-1:0] x,
                                         input logic [WIDTH-1:0] y,
                                         input logic             cin);
        logic [WIDTH:0]        wide;
        logic signed [WIDTH:0] sx;
        logic signed [WIDTH:0] sy;
        logic signed [WIDTH:0] sone;
        logic signed [WIDTH:0] scin;
        logic signed [WIDTH:0] swide;
        logic [WIDTH-1:0]      r;
        logic [WIDTH-1:0]      nz;
        logic                  c;
        logic                  arith;
        alu_out_t              o;
        sx    = {x[WIDTH-1], x};
        sy    = {y[WIDTH-1], y};
        sone  = {{WIDTH{1'b0}}, 1'b1};
        scin  = {{WIDTH{1'b0}}, cin};
        wide  = '0;
        swide = '0;
        r     = '0;
        c     = 1'b0;
        arith = 1'b0;
        case (op)
            OP_ADD: begin
                wide  = {1'b0, x} + {1'b0, y};
                swide = sx + sy;
                arith = 1'b1;
            end
            OP_ADC: begin
                wide  = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
                swide = sx + sy + scin;
                arith = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                wide  = {1'b0, x} - {1'b0, y};
                swide = sx - sy;
                arith = 1'b1;
            end
            OP_INC: begin
                wide  = {1'b0, x} + 1'b1;
                swide = sx + sone;
                arith = 1'b1;
            end
            OP_DEC: begin
                wide  = {1'b0, x} - 1'b1;
                swide = sx - sone;
                arith = 1'b1;
            end
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_NOT:  r = ~x;
            OP_NAND: r = ~(x & y);
            OP_NOR:  r = ~(x | y);
            OP_XNOR: r = ~(x ^ y);
            OP_SHL: begin
                r = {x[WIDTH-2:0], 1'b0};
                c = x[WIDTH-1];
            end
            OP_SHR: begin
                r = {1'b0, x[WIDTH-1:1]};
                c = x[0];
            end
            default: r = '0;
        endcase
        if (arith) begin
            r = (op == OP_CMP) ? x : wide[WIDTH-1:0];
            c = wide[WIDTH];
        end
        // CMP reports n/z of the difference, not of the passed-through operand.
        nz       = (op == OP_CMP) ? wide[WIDTH-1:0] : r;
        o.result = r;
        o.flags  = pack_flags(c, arith & (swide[WIDTH] ^ swide[WIDTH-1]),
                              nz[WIDTH-1], nz == '0);
        return o;
    endfunction

    always_comb begin
        in_ready_c = ((state == ST_IDLE) && !vld_p1) || (vld_p1 && bus.out_ready);
        accept     = bus.in_valid && in_ready_c;
        is_mul_op  = MUL_EN && (bus.s == OP_MUL);
        mul_start  = accept && is_mul_op;
        op_eff     = (bus.s == OP_MUL) ? OP_ADD : bus.s;
        single_out = eval_op(op_eff, bus.a, bus.b, carry_p1);
        mul_out.result = mul_prod[WIDTH-1:0];
        mul_out.flags  = pack_flags(|mul_prod[2*WIDTH-1:WIDTH], 1'b0,
                                    mul_prod[WIDTH-1], mul_prod[WIDTH-1:0] == '0);
    end

    alu_shift_add_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (bus.a),
        .b       (bus.b),
        .product (mul_prod),
        .done    (mul_done)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = is_mul_op ? ST_MUL : ST_HOLD;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    state_nxt = is_mul_op ? ST_MUL : ST_HOLD;
                end else if (bus.out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- result register stage (p1) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            result_p1 <= '0;
            flags_p1  <= '0;
            vld_p1    <= 1'b0;
            carry_p1  <= 1'b0;
        end else if (accept && !is_mul_op) begin
            result_p1 <= single_out.result;
            flags_p1  <= single_out.flags;
            carry_p1  <= single_out.flags[FLAG_C];
            vld_p1    <= 1'b1;
        end else if ((state == ST_MUL) && mul_done) begin
            result_p1 <= mul_out.result;
            flags_p1  <= mul_out.flags;
            carry_p1  <= mul_out.flags[FLAG_C];
            vld_p1    <= 1'b1;
        end else if (vld_p1 && bus.out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.alu_result = result_p1;
    assign bus.flags      = flags_p1;
    assign bus.out_valid  = vld_p1;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): a table of single-cycle ops with
// hand-computed results, then multiply, backpressure and reset sequences.
module tb_alu_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(8)) bus ();

    alu_seq #(
        .WIDTH  (8),
        .MUL_EN (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] s;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [3:0] flg;   // {c, v, n, z}
        logic [3:0] mask;  // flag bits that are compared
    } vec_t;

    vec_t vecs [19];
    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Called at a negedge; returns at the negedge one cycle after acceptance.
    task automatic issue(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
        int guard = 0;
        #1;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("issue_in_ready", bus.in_ready, 1);
        bus.s        = s;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = ~a;
        bus.b        = ~b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int ok;

        vecs[0]  = '{OP_ADD,  8'h7E, 8'h5F, 8'hDD, 4'b0110, 4'hF};
        vecs[1]  = '{OP_SUB,  8'h02, 8'h43, 8'hBF, 4'b1010, 4'hF};
        vecs[2]  = '{OP_ADC,  8'h10, 8'h01, 8'h12, 4'b0000, 4'hF};
        vecs[3]  = '{OP_AND,  8'hF0, 8'h3C, 8'h30, 4'b0000, 4'hF};
        vecs[4]  = '{OP_OR,   8'h0F, 8'h30, 8'h3F, 4'b0000, 4'hF};
        vecs[5]  = '{OP_XOR,  8'hFF, 8'hFF, 8'h00, 4'b0001, 4'hF};
        vecs[6]  = '{OP_NOT,  8'h55, 8'h00, 8'hAA, 4'b0010, 4'hF};
        vecs[7]  = '{OP_SHL,  8'h81, 8'h00, 8'h02, 4'b1000, 4'hF};
        vecs[8]  = '{OP_SHR,  8'h81, 8'h00, 8'h40, 4'b1000, 4'hF};
        vecs[9]  = '{OP_INC,  8'hFF, 8'h00, 8'h00, 4'b1001, 4'hF};
        vecs[10] = '{OP_DEC,  8'h00, 8'h00, 8'hFF, 4'b1010, 4'hF};
        vecs[11] = '{OP_NAND, 8'hFF, 8'h0F, 8'hF0, 4'b0010, 4'hF};
        vecs[12] = '{OP_NOR,  8'h00, 8'h00, 8'hFF, 4'b0010, 4'hF};
        vecs[13] = '{OP_XNOR, 8'hA5, 8'hA5, 8'hFF, 4'b0010, 4'hF};
        vecs[14] = '{OP_CMP,  8'h23, 8'h98, 8'h23, 4'b1100, 4'b1101};
        vecs[15] = '{OP_INC,  8'h7F, 8'h00, 8'h80, 4'b0110, 4'hF};
        vecs[16] = '{OP_ADD,  8'h80, 8'h80, 8'h00, 4'b1101, 4'hF};
        vecs[17] = '{OP_ADC,  8'h01, 8'h01, 8'h03, 4'b0000, 4'hF};
        vecs[18] = '{OP_SUB,  8'h80, 8'h01, 8'h7F, 4'b0100, 4'hF};

        // Reset with a pending request: nothing may be accepted.
        rst = 1'b1;
        bus.in_valid  = 1'b1;
        bus.s         = OP_ADD;
        bus.a         = 8'h01;
        bus.b         = 8'h01;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result", bus.alu_result, 0);
        check("rst_flags", bus.flags, 0);
        check("rst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        check("rst_no_accept", bus.out_valid, 0);

        for (int i = 0; i < 19; i++) begin
            issue(vecs[i].s, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_valid", i), bus.out_valid, 1);
            check($sformatf("vec%0d_result", i), bus.alu_result, vecs[i].res);
            check($sformatf("vec%0d_flags", i), bus.flags & vecs[i].mask,
                  vecs[i].flg & vecs[i].mask);
        end

        // Multiply: 0x2C*0x18 = 0x420, visible in the 9th cycle after acceptance.
        issue(OP_MUL, 8'h2C, 8'h18);
        lat = 1;
        ok  = 1;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            if (bus.in_ready !== 1'b0) ok = 0;
            @(negedge clk);
            lat++;
        end
        check("mul_latency", lat, 9);
        check("mul_in_ready_low", ok, 1);
        check("mul_result", bus.alu_result, 8'h20);
        check("mul_flags", bus.flags, 4'b1000);
        issue(OP_ADC, 8'h00, 8'h00);
        check("adc_after_mul", bus.alu_result, 8'h01);

        // Backpressure, then back-to-back acceptance of a waiting request.
        @(negedge clk);
        bus.out_ready = 1'b0;
        issue(OP_ADD, 8'h7E, 8'h5F);
        bus.s        = OP_SUB;
        bus.a        = 8'h05;
        bus.b        = 8'h03;
        bus.in_valid = 1'b1;
        ok = 1;
        for (int k = 0; k < 5; k++) begin
            if (bus.out_valid !== 1'b1 || bus.alu_result !== 8'hDD ||
                bus.flags !== 4'b0110 || bus.in_ready !== 1'b0) ok = 0;
            @(negedge clk);
        end
        check("bp_hold_stable", ok, 1);
        check("bp_result_held", bus.alu_result, 8'hDD);
        bus.out_ready = 1'b1;
        #1;
        check("bp_in_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("b2b_valid", bus.out_valid, 1);
        check("b2b_result", bus.alu_result, 8'h02);
        check("b2b_flags", bus.flags, 4'b0000);

        // Reset three cycles into a multiply; stored carry was set by INC 0xFF.
        issue(OP_INC, 8'hFF, 8'h00);
        issue(OP_MUL, 8'h2C, 8'h18);
        repeat (2) @(negedge clk);
        rst          = 1'b1;
        bus.s        = OP_ADD;
        bus.a        = 8'h40;
        bus.b        = 8'h40;
        bus.in_valid = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        ok = 1;
        for (int k = 0; k < 12; k++) begin
            if (bus.out_valid !== 1'b0) ok = 0;
            @(negedge clk);
        end
        check("abort_no_valid", ok, 1);
        check("abort_flags", bus.flags, 0);
        check("abort_result", bus.alu_result, 0);
        check("abort_in_ready", bus.in_ready, 1);
        issue(OP_ADC, 8'h01, 8'h01);
        check("abort_carry_cleared", bus.alu_result, 8'h02);
        issue(OP_ADD, 8'h01, 8'h01);
        check("post_abort_add", bus.alu_result, 8'h02);
        check("post_abort_valid", bus.out_valid, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving operand and result width (legal range 4..32).
REQ-002 The block SHALL have parameter MUL_EN, default 1; when 1, op 4'b1110 is a multi-cycle multiply, and when 0 it executes as op 4'b0000 (ADD).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 a  input  WIDTH  operand A.
REQ-006 b  input  WIDTH  operand B.
REQ-007 s  input  4  operation select.
REQ-008 in_valid  input  1  a/b/s valid this cycle.
REQ-009 in_ready  output  1  block can accept an operation.
REQ-010 alu_result  output  WIDTH  registered result.
REQ-011 flags  output  4  registered {c, v, n, z}.
REQ-012 out_valid  output  1  alu_result/flags hold a completed result.
REQ-013 out_ready  input  1  consumer accepts the result.

Function
REQ-014 Ops SHALL be:
- 0 ADD a+b
- 1 SUB a-b
- 2 AND
- 3 OR
- 4 XOR
- 5 NOT a
- 6 SHL a by 1
- 7 SHR a by 1 (logical)
- 8 INC a
- 9 DEC a
- A NAND
- B NOR
- C XNOR
- D CMP (result=a, flags from a-b)
- E MUL (low WIDTH bits of a*b)
- F ADC a+b+stored c
REQ-015 An operation SHALL be accepted on a cycle with in_valid=1 and in_ready=1.
- in_ready=1 only in state IDLE with no result pending (out_valid=0), or when out_valid=1 and out_ready=1 in the same cycle.
REQ-016 Single-cycle ops SHALL have out_valid=1 with the result on the cycle after acceptance (latency 1).
REQ-017 The FSM SHALL have states IDLE, MUL, HOLD:
- IDLE -> MUL on an accepted op E (MUL_EN=1).
- IDLE -> HOLD on an accepted single-cycle op.
- MUL -> HOLD after WIDTH shift-add iterations.
- HOLD -> IDLE on out_ready=1, or HOLD -> HOLD/MUL if a new op is accepted in that same cycle.
REQ-018 MUL SHALL take exactly WIDTH cycles in state MUL; out_valid rises WIDTH+1 cycles after acceptance, and in_ready=0 throughout.
REQ-019 While out_valid=1 and out_ready=0, alu_result, flags and out_valid SHALL hold unchanged.
REQ-020 Arithmetic SHALL use a WIDTH+1-bit internal sum.
- c for ADD/ADC/INC: carry out.
- c for SUB/CMP/DEC: borrow (1 when the unsigned minuend < subtrahend).
- c for SHL/SHR: the shifted-out bit.
- c for MUL: 1 if any product bit above WIDTH-1 is nonzero.
- c for logic ops: 0.
REQ-021 v SHALL be signed two's-complement overflow for ADD/ADC/SUB/CMP/INC/DEC and 0 otherwise; n SHALL equal result MSB; z SHALL equal (result==0).
REQ-022 A stored carry register SHALL update with c on every completed op and SHALL feed ADC.
REQ-023 Wrap-around SHALL be modulo 2^WIDTH; INC of all-ones gives 0 with c=1, and DEC of 0 gives all-ones with c=1.
REQ-024 Inputs a/b/s SHALL be ignored when not accepted; MUL SHALL use operands captured at acceptance.

Reset
REQ-025 On rst=1 at a clock edge, the block SHALL clear state to IDLE, alu_result=0, flags=0, out_valid=0 and stored carry=0, with in_ready=1 on the following cycle.
REQ-026 Reset during MUL or HOLD SHALL abort the operation with no result emitted; reset SHALL dominate a simultaneous in_valid.

Structure
REQ-027 A shared package alu_pkg SHALL hold the 4-bit opcode constants, the FSM state encoding, and the flag bit indices.
REQ-028 The multiplier datapath SHALL be a sub-module alu_shift_add_mul (WIDTH parameter, start/done) and everything else inline.

Verification
REQ-029 WIDTH=8, ADD a=0x7E, b=0x5F -> alu_result=0xDD, flags c=0, v=1, n=1, z=0, one cycle after acceptance.
REQ-030 SUB a=0x02, b=0x43 -> 0xBF, c=1, n=1; then ADC a=0x10, b=0x01 -> 0x12.
REQ-031 MUL a=0x2C, b=0x18 -> 0x20, c=1, out_valid 9 cycles after acceptance, in_ready=0 in between.
REQ-032 ADD result with out_ready=0 for 5 cycles -> result and flags stable, in_ready=0; out_ready=1 with new in_valid -> back-to-back acceptance.
REQ-033 Assert rst 3 cycles into MUL -> out_valid never rises, flags=0, next ADD 0x01+0x01 -> 0x02.
REQ-034 INC 0xFF -> 0x00, z=1, c=1; DEC 0x00 -> 0xFF, c=1; CMP 0x23 vs 0x98 -> result 0x23, c=1.
